tx_fifo_mgnt: RTL and testbench

//  Transmit-side FIFO manager; mirror of the rx path FIFO manager. Accepts client frames
//  (64-bit words + 8-bit byte-lane mask) after a start/ack handshake. Buffers them with

---
 rtl/tx_fifo_mgnt.sv | 174 +++++++++++++++++
 tb/tb_tx_fifo_mgnt.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_mgnt.sv
// Transmit FIFO manager: client start/ack handshake, one-word hold pipeline, frame-tagged FIFO to the tx engine.
// Optional frame/overflow statistics outputs are built when TX_FIFO_STATS_EN is defined.
module tx_fifo_mgnt #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned ACK_THRESH = 192
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic        tx_start,
  output logic        tx_ack,
  input  logic [63:0] tx_data,
  input  logic [7:0]  tx_data_valid,
  output logic        tx_overflow,
  output logic        tx_frame_avail,
  input  logic        txfifo_rd_en,
  output logic [63:0] txd64,
  output logic [7:0]  txc_fifo,
  output logic        txd_last,
  output logic        txd_err,
  output logic        txfifo_empty
`ifdef TX_FIFO_STATS_EN
  ,
  output logic [15:0] tx_frame_count,
  output logic [15:0] tx_ovfl_count
`endif
);

  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LIMIT    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_THRESH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACKED, S_RECV, S_FLUSH} state_e;
  state_e state_q, state_d;

  logic [73:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d, frame_cnt_q, frame_cnt_d, free;
  logic [63:0]           hold_data_q, hold_data_d;
  logic [7:0]            hold_mask_q, hold_mask_d;
  logic                  hold_vld_q, hold_vld_d;
  logic                  err_q, err_d, ovf_q, avail_q;
  logic [73:0]           rd_word_q, wr_word;
  logic                  wr_req, wr_last, wr_ok, wr_en, drop, rd_en, rd_last;

  assign free = FULL_CNT - count_q;

  always_ff @(posedge txclk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tx_start) state_d = S_WAIT;
      S_WAIT:  if (free >= ACK_LIM) state_d = S_ACKED;
      S_ACKED: state_d = S_RECV;
      S_RECV:  if (tx_data_valid != 8'hFF) state_d = S_FLUSH;
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ack = (state_q == S_ACKED);
  end

  // Each accepted word is parked in the hold register; the word it displaces is written,
  // so its last tag can depend on whether the next client word is the 8'h00 terminator.
  always_comb begin
    wr_req      = 1'b0;
    wr_last     = 1'b0;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    hold_vld_d  = hold_vld_q;
    if (state_q == S_RECV) begin
      if (hold_vld_q) begin
        wr_req  = 1'b1;
        wr_last = (hold_mask_q != 8'hFF) | (tx_data_valid == 8'h00);
      end
      hold_vld_d = (tx_data_valid != 8'h00);
      if (tx_data_valid != 8'h00) begin
        hold_data_d = tx_data;
        hold_mask_d = tx_data_valid;
      end
    end else if (state_q == S_FLUSH) begin
      wr_req     = hold_vld_q;
      wr_last    = hold_vld_q;
      hold_vld_d = 1'b0;
    end

    wr_ok   = wr_last ? (count_q != FULL_CNT) : (count_q < LIMIT);
    wr_en   = wr_req & wr_ok;
    drop    = wr_req & ~wr_ok;
    wr_word = {wr_last, wr_last & err_q, hold_mask_q, hold_data_q};

    err_d = err_q;
    if (wr_req && wr_last) err_d = 1'b0;
    else if (drop)         err_d = 1'b1;

    rd_en   = txfifo_rd_en & (count_q != '0);
    rd_last = mem_q[rd_ptr_q][73];

    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + CW'(1);
    else if (rd_en && !wr_en) count_d = count_q - CW'(1);

    frame_cnt_d = frame_cnt_q;
    if ((wr_en && wr_last) && !(rd_en && rd_last))      frame_cnt_d = frame_cnt_q + CW'(1);
    else if ((rd_en && rd_last) && !(wr_en && wr_last)) frame_cnt_d = frame_cnt_q - CW'(1);
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      hold_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      avail_q     <= 1'b0;
      rd_word_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + DEPTH_LOG2'(1);
        rd_word_q <= mem_q[rd_ptr_q];
      end
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      hold_vld_q  <= hold_vld_d;
      err_q       <= err_d;
      ovf_q       <= drop;
      avail_q     <= (frame_cnt_d != '0);
    end
  end

  always_ff @(posedge txclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  end

  assign tx_overflow    = ovf_q;
  assign tx_frame_avail = avail_q;
  assign txfifo_empty   = (count_q == '0);
  assign txd64          = rd_word_q[63:0];
  assign txc_fifo       = rd_word_q[71:64];
  assign txd_err        = rd_word_q[72];
  assign txd_last       = rd_word_q[73];

`ifdef TX_FIFO_STATS_EN
  logic [15:0] frame_stat_q, ovfl_stat_q;

  always_ff @(posedge txclk) begin
    if (reset) begin
      frame_stat_q <= '0;
      ovfl_stat_q  <= '0;
    end else begin
      if (wr_en && wr_last && frame_stat_q != '1) frame_stat_q <= frame_stat_q + 16'd1;
      if (drop && ovfl_stat_q != '1)              ovfl_stat_q  <= ovfl_stat_q + 16'd1;
    end
  end

  assign tx_frame_count = frame_stat_q;
  assign tx_ovfl_count  = ovfl_stat_q;
`endif

endmodule

// File: tb/tb_tx_fifo_mgnt.sv
// Bench for tx_fifo_mgnt: cycle vector table for basic frames, hand sequences for overflow,
// concurrent last read/write, and reset in the middle of a frame.
module tb_tx_fifo_mgnt;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_start;
  logic        tx_ack;
  logic [63:0] tx_data;
  logic [7:0]  tx_data_valid;
  logic        tx_overflow;
  logic        tx_frame_avail;
  logic        txfifo_rd_en;
  logic [63:0] txd64;
  logic [7:0]  txc_fifo;
  logic        txd_last;
  logic        txd_err;
  logic        txfifo_empty;
`ifdef TX_FIFO_STATS_EN
  logic [15:0] tx_frame_count;
  logic [15:0] tx_ovfl_count;
`endif

  tx_fifo_mgnt #(.DEPTH_LOG2(4), .ACK_THRESH(6)) dut (
    .txclk          (clk),
    .reset          (rst),
    .tx_start       (tx_start),
    .tx_ack         (tx_ack),
    .tx_data        (tx_data),
    .tx_data_valid  (tx_data_valid),
    .tx_overflow    (tx_overflow),
    .tx_frame_avail (tx_frame_avail),
    .txfifo_rd_en   (txfifo_rd_en),
    .txd64          (txd64),
    .txc_fifo       (txc_fifo),
    .txd_last       (txd_last),
    .txd_err        (txd_err),
    .txfifo_empty   (txfifo_empty)
`ifdef TX_FIFO_STATS_EN
    ,
    .tx_frame_count (tx_frame_count),
    .tx_ovfl_count  (tx_ovfl_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [63:0] data;
    logic [7:0]  mask;
    logic        rd;
    logic [3:0]  st;    // {ack, overflow, frame_avail, empty}
    logic [63:0] d;
    logic [7:0]  c;
    logic        last;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [63:0] Z  = 64'h0;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDE0;
  localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDE1;
  localparam logic [63:0] D2 = 64'h0123_4567_89AB_CDE2;
  localparam logic [63:0] E0 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] E1 = 64'hFEDC_BA98_7654_3211;
  localparam logic [63:0] F0 = 64'h0000_0000_0000_BEEF;

  task automatic add(input logic s, input logic [63:0] dat, input logic [7:0] m, input logic r,
                     input logic [3:0] st, input logic [63:0] d, input logic [7:0] c,
                     input logic l, input logic e);
    vec_t v;
    v.start = s; v.data = dat; v.mask = m; v.rd = r;
    v.st = st; v.d = d; v.c = c; v.last = l; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic [63:0] dat, input logic [7:0] m, input logic r);
    tx_start = s; tx_data = dat; tx_data_valid = m; txfifo_rd_en = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ow(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i);
  endfunction

  int ovf_seen, acks;

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_data = '0; tx_data_valid = '0; txfifo_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_status", 0, 128'({tx_ack, tx_overflow, tx_frame_avail, txfifo_empty}), 128'(4'b0001));
    check("reset_pop", 0, 128'({txd64, txc_fifo, txd_last, txd_err}), 128'(0));
    rst = 1'b0;

    // 3-word frame FF,FF,0F then pops, incl. pop while empty
    add(1, Z, 8'h00, 0, 4'b0001, Z, 8'h00, 0, 0);
    add(0, Z, 8'h00, 0, 4'b1001, Z, 8'h00, 0, 0);
    add(0, Z, 8'h00, 0, 4'b0001, Z, 8'h00, 0, 0);
    add(0, D0, 8'hFF, 0, 4'b0001, Z, 8'h00, 0, 0);
    add(0, D1, 8'hFF, 0, 4'b0000, Z, 8'h00, 0, 0);
    add(0, D2, 8'h0F, 0, 4'b0000, Z, 8'h00, 0, 0);
    add(0, Z, 8'h00, 0, 4'b0010, Z, 8'h00, 0, 0);
    add(0, Z, 8'h00, 1, 4'b0010, D0, 8'hFF, 0, 0);
    add(0, Z, 8'h00, 1, 4'b0010, D1, 8'hFF, 0, 0);
    add(0, Z, 8'h00, 1, 4'b0001, D2, 8'h0F, 1, 0);
    add(0, Z, 8'h00, 1, 4'b0001, D2, 8'h0F, 1, 0);
    // 2-word frame closed by 8'h00
    add(1, Z, 8'h00, 0, 4'b0001, D2, 8'h0F, 1, 0);
    add(0, Z, 8'h00, 0, 4'b1001, D2, 8'h0F, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0001, D2, 8'h0F, 1, 0);
    add(0, E0, 8'hFF, 0, 4'b0001, D2, 8'h0F, 1, 0);
    add(0, E1, 8'hFF, 0, 4'b0000, D2, 8'h0F, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0010, D2, 8'h0F, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0010, D2, 8'h0F, 1, 0);
    add(0, Z, 8'h00, 1, 4'b0010, E0, 8'hFF, 0, 0);
    add(0, Z, 8'h00, 1, 4'b0001, E1, 8'hFF, 1, 0);
    // empty frame: first word 8'h00, nothing stored
    add(1, Z, 8'h00, 0, 4'b0001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 0, 4'b1001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 1, 4'b0001, E1, 8'hFF, 1, 0);
    // single partial word frame
    add(1, Z, 8'h00, 0, 4'b0001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 0, 4'b1001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0001, E1, 8'hFF, 1, 0);
    add(0, F0, 8'h03, 0, 4'b0001, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 0, 4'b0010, E1, 8'hFF, 1, 0);
    add(0, Z, 8'h00, 1, 4'b0001, F0, 8'h03, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].start, tbl[i].data, tbl[i].mask, tbl[i].rd);
      check("vec_status", i, 128'({tx_ack, tx_overflow, tx_frame_avail, txfifo_empty}), 128'(tbl[i].st));
      check("vec_pop", i, 128'({txd64, txc_fifo, txd_last, txd_err}),
            128'({tbl[i].d, tbl[i].c, tbl[i].last, tbl[i].err}));
    end

    // Overflow: 20 FF words + 0F into a 16-entry FIFO; 15 body words fit, 5 dropped
    cyc(1, Z, 8'h00, 0);
    cyc(0, Z, 8'h00, 0);
    check("ovf_ack", 0, 128'(tx_ack), 128'(1));
    cyc(0, Z, 8'h00, 0);
    ovf_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, ow(i), 8'hFF, 0);
      ovf_seen += int'(tx_overflow);
    end
    cyc(0, ow(20), 8'h0F, 0);
    ovf_seen += int'(tx_overflow);
    cyc(0, Z, 8'h00, 0);
    ovf_seen += int'(tx_overflow);
    check("ovf_pulses", 0, 128'(ovf_seen), 128'(5));
    check("ovf_status", 0, 128'({tx_frame_avail, txfifo_empty}), 128'(2'b10));

    // Start while full: no ack until enough space is freed by pops
    cyc(1, Z, 8'h00, 0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, Z, 8'h00, 0);
      acks += int'(tx_ack);
    end
    check("full_no_ack", 0, 128'(acks), 128'(0));
    acks = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(0, Z, 8'h00, 1);
      acks += int'(tx_ack);
      if (k < 15) check("ovf_pop", k, 128'({txd64, txc_fifo, txd_last, txd_err}), 128'({ow(k), 8'hFF, 1'b0, 1'b0}));
      else        check("ovf_pop", k, 128'({txd64, txc_fifo, txd_last, txd_err}), 128'({ow(20), 8'h0F, 1'b1, 1'b1}));
    end
    check("ack_after_drain", 0, 128'(acks), 128'(1));
    repeat (3) cyc(0, Z, 8'h00, 0);
    check("drained", 0, 128'({tx_frame_avail, txfifo_empty}), 128'(2'b01));

    // Last-word write of frame Y coincides with last-word pop of frame X
    cyc(1, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0);
    cyc(0, D0, 8'h0F, 0); cyc(0, Z, 8'h00, 0);
    check("x_avail", 0, 128'(tx_frame_avail), 128'(1));
    cyc(1, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0);
    cyc(0, E0, 8'hFF, 0); cyc(0, E1, 8'h0F, 0);
    cyc(0, Z, 8'h00, 1);
    check("rw_same_avail", 0, 128'(tx_frame_avail), 128'(1));
    check("rw_same_pop", 0, 128'({txd64, txc_fifo, txd_last, txd_err}), 128'({D0, 8'h0F, 1'b1, 1'b0}));
    cyc(0, Z, 8'h00, 1);
    check("y0_pop", 0, 128'({tx_frame_avail, txd64, txc_fifo, txd_last}), 128'({1'b1, E0, 8'hFF, 1'b0}));
    cyc(0, Z, 8'h00, 1);
    check("y1_pop", 0, 128'({tx_frame_avail, txfifo_empty, txd64, txc_fifo, txd_last}),
          128'({1'b0, 1'b1, E1, 8'h0F, 1'b1}));

    // Reset in the middle of a frame, with a complete frame already buffered
    cyc(1, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0);
    cyc(0, F0, 8'h0F, 0); cyc(0, Z, 8'h00, 0);
    cyc(1, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0);
    cyc(0, D0, 8'hFF, 0); cyc(0, D1, 8'hFF, 0);
    check("pre_reset", 0, 128'({tx_frame_avail, txfifo_empty}), 128'(2'b10));
    rst = 1'b1;
    cyc(0, D2, 8'hFF, 0);
    rst = 1'b0;
    check("mid_reset_status", 0, 128'({tx_ack, tx_overflow, tx_frame_avail, txfifo_empty}), 128'(4'b0001));
    cyc(0, Z, 8'h00, 1);
    check("post_reset_pop", 0, 128'({txfifo_empty, txd64, txc_fifo, txd_last, txd_err}), 128'({1'b1, 74'h0}));
    cyc(1, Z, 8'h00, 0);
    cyc(0, Z, 8'h00, 0);
    check("post_reset_ack", 0, 128'(tx_ack), 128'(1));
    cyc(0, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0); cyc(0, Z, 8'h00, 0);
    check("post_reset_empty", 0, 128'({tx_frame_avail, txfifo_empty}), 128'(2'b01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
